// File: rtl/branch_resolver_pkg.sv
// branch_resolver_pkg: shared types and helpers for the branch resolver
package branch_resolver_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } bp_entry_t;
  typedef enum logic {RUN, FLUSH} resolver_state_t;
  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == STAT_MAX) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/branch_resolver_if.sv
// branch_resolver_if: fetch record, EX resolve, recovery and BHT training bundle
// master: the pipeline side (drives fetch_*/res_*); slave: the resolver
interface branch_resolver_if #(parameter int IDX_W = 10);
  logic             fetch_valid;
  logic [31:0]      fetch_pc;
  logic             fetch_pred_taken;
  logic [31:0]      fetch_pred_target;
  logic             fetch_ready;
  logic             res_valid;
  logic             res_is_jump;
  logic             res_br_en;
  logic [31:0]      res_target;
  logic             res_ready;
  logic             flush;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             upd_jump;
  logic [31:0]      stat_branches;
  logic [31:0]      stat_mispredicts;
  modport master (
    output fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    output res_valid, res_is_jump, res_br_en, res_target,
    input  fetch_ready, res_ready, flush, redirect_valid, redirect_pc,
    input  upd_valid, upd_index, upd_taken, upd_jump, stat_branches, stat_mispredicts
  );
  modport slave (
    input  fetch_valid, fetch_pc, fetch_pred_taken, fetch_pred_target,
    input  res_valid, res_is_jump, res_br_en, res_target,
    output fetch_ready, res_ready, flush, redirect_valid, redirect_pc,
    output upd_valid, upd_index, upd_taken, upd_jump, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolver_pred_queue.sv
// pred_queue: in-order FIFO of outstanding predictions
// push/pop/clear in, full/empty/head out; clear wins over a same-cycle push
module pred_queue
  import branch_resolver_pkg::*;
#(parameter int DEPTH = 4)
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  logic      clear,
  input  bp_entry_t din,
  output logic      full,
  output logic      empty,
  output bp_entry_t head
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  bp_entry_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign head  = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/branch_resolver.sv
// branch_resolver: resolves queued predictions at EX, drives flush/redirect and BHT training
// clk, rst_n (async active-low); bus: slave side of branch_resolver_if
module branch_resolver
  import branch_resolver_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int IDX_W        = 10,
  parameter int FLUSH_CYCLES = 2
)
(
  input  logic clk,
  input  logic rst_n,
  branch_resolver_if.slave bus
);
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  resolver_state_t state;
  logic [FW-1:0] fcnt;
  logic full, empty, push, pop, actual, mis;
  logic [31:0] correct_pc, stat_br_q, stat_mis_q, redirect_pc_q;
  logic redirect_valid_q, upd_valid_q, upd_taken_q, upd_jump_q;
  logic [IDX_W-1:0] upd_index_q;
  bp_entry_t head;
  assign bus.fetch_ready = (state == RUN) && !full;
  assign bus.res_ready   = (state == RUN) && !empty;
  assign push       = bus.fetch_valid && bus.fetch_ready;
  assign pop        = bus.res_valid && bus.res_ready;
  assign actual     = bus.res_br_en | bus.res_is_jump;
  assign mis        = pop && ((actual != head.pred_taken) || (actual && head.pred_target != bus.res_target));
  assign correct_pc = actual ? bus.res_target : head.pc + 32'd4;
  pred_queue #(.DEPTH(DEPTH)) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .clear (mis),
    .din   ('{pc: bus.fetch_pc, pred_taken: bus.fetch_pred_taken, pred_target: bus.fetch_pred_target}),
    .full  (full),
    .empty (empty),
    .head  (head)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state            <= RUN;
      fcnt             <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      upd_valid_q      <= 1'b0;
      upd_index_q      <= '0;
      upd_taken_q      <= 1'b0;
      upd_jump_q       <= 1'b0;
      stat_br_q        <= '0;
      stat_mis_q       <= '0;
    end else begin
      upd_valid_q      <= pop;
      redirect_valid_q <= mis;
      if (pop) begin
        upd_index_q <= head.pc[IDX_W-1:0];
        upd_taken_q <= actual;
        upd_jump_q  <= bus.res_is_jump;
        stat_br_q   <= sat_inc(stat_br_q);
      end
      if (mis) begin
        redirect_pc_q <= correct_pc;
        stat_mis_q    <= sat_inc(stat_mis_q);
        state         <= FLUSH;
        fcnt          <= FW'(FLUSH_CYCLES - 1);
      end else if (state == FLUSH) begin
        if (fcnt == '0) state <= RUN;
        else fcnt <= fcnt - 1'b1;
      end
    end
  assign bus.flush            = state == FLUSH;
  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.upd_valid        = upd_valid_q;
  assign bus.upd_index        = upd_index_q;
  assign bus.upd_taken        = upd_taken_q;
  assign bus.upd_jump         = upd_jump_q;
  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mis_q;
endmodule

// File: tb/tb_branch_resolver.sv
// tb_branch_resolver: directed vector table, corner sequences and randomized model check
module tb_branch_resolver;
  import branch_resolver_pkg::*;
  localparam int DEPTH = 4, IDX_W = 10, FC = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  branch_resolver_if #(.IDX_W(IDX_W)) bus();
  branch_resolver #(.DEPTH(DEPTH), .IDX_W(IDX_W), .FLUSH_CYCLES(FC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic [31:0] fv, pc, pt, ptg, rv, rj, rb, rt;
    logic [31:0] fr, rr, uv, idx, ut, uj, rdv, rpc, fl, sb, sm;
  } vec_t;
  vec_t vq[$];
  int n_cmp = 0, n_bad = 0;
  bp_entry_t mq[$];
  bp_entry_t h;
  int fl_left;
  logic [31:0] m_br, m_mis, e_rpc, r_pc, r_ptg, r_rt;
  logic [IDX_W-1:0] e_idx;
  bit m_fr, m_rr, e_uv, e_ut, e_uj, e_rv, pop, push, mis, act, r_fv, r_pt, r_rv, r_rj, r_rb;
  task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h at %0t", name, act_v, exp_v, $time);
    end
  endtask
  task automatic drive(input logic fv, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                       input logic rv, input logic rj, input logic rb, input logic [31:0] rt);
    bus.fetch_valid       = fv;
    bus.fetch_pc          = pc;
    bus.fetch_pred_taken  = pt;
    bus.fetch_pred_target = ptg;
    bus.res_valid         = rv;
    bus.res_is_jump       = rj;
    bus.res_br_en         = rb;
    bus.res_target        = rt;
  endtask
  task automatic cyc(input logic fv, input logic [31:0] pc, input logic pt, input logic [31:0] ptg,
                     input logic rv, input logic rj, input logic rb, input logic [31:0] rt);
    @(negedge clk);
    drive(fv, pc, pt, ptg, rv, rj, rb, rt);
    @(posedge clk);
    #1;
  endtask
  initial begin
    //            fv pc     pt ptg     rv rj rb rt      fr rr uv idx    ut uj rdv rpc    fl sb sm
    vq.push_back('{1, 'h100, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0,      0, 0, 0});
    vq.push_back('{0, 0,     0, 0,      1, 0, 0, 'h999,  1, 1, 1, 'h100, 0, 0, 0, 0,      0, 1, 0});
    vq.push_back('{1, 'h200, 0, 0,      0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0,      0, 1, 0});
    vq.push_back('{0, 0,     0, 0,      1, 0, 1, 'h280,  1, 1, 1, 'h200, 1, 0, 1, 'h280,  1, 2, 1});
    vq.push_back('{1, 'h300, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      1, 2, 1});
    vq.push_back('{1, 'h300, 0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      0, 2, 1});
    vq.push_back('{1, 'h300, 1, 'h400,  0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0,      0, 2, 1});
    vq.push_back('{0, 0,     0, 0,      1, 1, 0, 'h404,  1, 1, 1, 'h300, 1, 1, 1, 'h404,  1, 3, 2});
    vq.push_back('{0, 0,     0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      1, 3, 2});
    vq.push_back('{0, 0,     0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      0, 3, 2});
    vq.push_back('{1, 'h10,  0, 0,      0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0,      0, 3, 2});
    vq.push_back('{1, 'h14,  0, 0,      0, 0, 0, 0,      1, 1, 0, 0,     0, 0, 0, 0,      0, 3, 2});
    vq.push_back('{1, 'h18,  0, 0,      0, 0, 0, 0,      1, 1, 0, 0,     0, 0, 0, 0,      0, 3, 2});
    vq.push_back('{1, 'h1C,  0, 0,      0, 0, 0, 0,      1, 1, 0, 0,     0, 0, 0, 0,      0, 3, 2});
    vq.push_back('{1, 'h20,  0, 0,      0, 0, 0, 0,      0, 1, 0, 0,     0, 0, 0, 0,      0, 3, 2});
    vq.push_back('{0, 0,     0, 0,      1, 0, 0, 0,      0, 1, 1, 'h10,  0, 0, 0, 0,      0, 4, 2});
    vq.push_back('{1, 'h20,  0, 0,      1, 0, 0, 0,      1, 1, 1, 'h14,  0, 0, 0, 0,      0, 5, 2});
    vq.push_back('{1, 'h24,  0, 0,      0, 0, 0, 0,      1, 1, 0, 0,     0, 0, 0, 0,      0, 5, 2});
    vq.push_back('{1, 'h28,  0, 0,      1, 0, 0, 0,      0, 1, 1, 'h18,  0, 0, 0, 0,      0, 6, 2});
    vq.push_back('{1, 'h28,  0, 0,      1, 0, 1, 'h50,   1, 1, 1, 'h1C,  1, 0, 1, 'h50,   1, 7, 3});
    vq.push_back('{0, 0,     0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      1, 7, 3});
    vq.push_back('{0, 0,     0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      0, 7, 3});
    vq.push_back('{0, 0,     0, 0,      1, 0, 1, 'h60,   1, 0, 0, 0,     0, 0, 0, 0,      0, 7, 3});
    vq.push_back('{1, 'h500, 1, 'h600,  0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0,      0, 7, 3});
    vq.push_back('{0, 0,     0, 0,      1, 0, 1, 'h600,  1, 1, 1, 'h100, 1, 0, 0, 0,      0, 8, 3});
    vq.push_back('{1, 'h800, 1, 'h900,  0, 0, 0, 0,      1, 0, 0, 0,     0, 0, 0, 0,      0, 8, 3});
    vq.push_back('{0, 0,     0, 0,      1, 0, 0, 0,      1, 1, 1, 'h0,   0, 0, 1, 'h804,  1, 9, 4});
    vq.push_back('{0, 0,     0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      1, 9, 4});
    vq.push_back('{0, 0,     0, 0,      0, 0, 0, 0,      0, 0, 0, 0,     0, 0, 0, 0,      0, 9, 4});
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst fetch_ready", {31'b0, bus.fetch_ready}, 1);
    chk("rst res_ready", {31'b0, bus.res_ready}, 0);
    chk("rst flush", {31'b0, bus.flush}, 0);
    chk("rst upd_valid", {31'b0, bus.upd_valid}, 0);
    chk("rst redirect_valid", {31'b0, bus.redirect_valid}, 0);
    chk("rst redirect_pc", bus.redirect_pc, 0);
    chk("rst upd_index", {22'b0, bus.upd_index}, 0);
    chk("rst stat_branches", bus.stat_branches, 0);
    chk("rst stat_mispredicts", bus.stat_mispredicts, 0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i].fv[0], vq[i].pc, vq[i].pt[0], vq[i].ptg, vq[i].rv[0], vq[i].rj[0], vq[i].rb[0], vq[i].rt);
      #1;
      chk($sformatf("v%0d fetch_ready", i), {31'b0, bus.fetch_ready}, vq[i].fr);
      chk($sformatf("v%0d res_ready", i), {31'b0, bus.res_ready}, vq[i].rr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d upd_valid", i), {31'b0, bus.upd_valid}, vq[i].uv);
      chk($sformatf("v%0d redirect_valid", i), {31'b0, bus.redirect_valid}, vq[i].rdv);
      chk($sformatf("v%0d flush", i), {31'b0, bus.flush}, vq[i].fl);
      chk($sformatf("v%0d stat_branches", i), bus.stat_branches, vq[i].sb);
      chk($sformatf("v%0d stat_mispredicts", i), bus.stat_mispredicts, vq[i].sm);
      if (vq[i].uv[0]) begin
        chk($sformatf("v%0d upd_index", i), {22'b0, bus.upd_index}, vq[i].idx);
        chk($sformatf("v%0d upd_taken", i), {31'b0, bus.upd_taken}, vq[i].ut);
        chk($sformatf("v%0d upd_jump", i), {31'b0, bus.upd_jump}, vq[i].uj);
      end
      if (vq[i].rdv[0]) chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vq[i].rpc);
    end
    cyc(1, 'h700, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 'h740);
    chk("midflush flush_set", {31'b0, bus.flush}, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("midflush flush", {31'b0, bus.flush}, 0);
    chk("midflush fetch_ready", {31'b0, bus.fetch_ready}, 1);
    chk("midflush res_ready", {31'b0, bus.res_ready}, 0);
    chk("midflush redirect_valid", {31'b0, bus.redirect_valid}, 0);
    chk("midflush upd_valid", {31'b0, bus.upd_valid}, 0);
    chk("midflush stat_branches", bus.stat_branches, 0);
    chk("midflush stat_mispredicts", bus.stat_mispredicts, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0, 0);
    chk("postrst empty upd_valid", {31'b0, bus.upd_valid}, 0);
    chk("postrst empty res_ready", {31'b0, bus.res_ready}, 0);
    @(negedge clk);
    force dut.stat_mis_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_mis_q;
    #1;
    chk("sat preload", bus.stat_mispredicts, 32'hFFFF_FFFF);
    cyc(1, 'h40, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 1, 'h80);
    chk("sat stat_mispredicts", bus.stat_mispredicts, 32'hFFFF_FFFF);
    chk("sat stat_branches", bus.stat_branches, 1);
    chk("sat redirect_pc", bus.redirect_pc, 'h80);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    fl_left = 0;
    m_br = 0;
    m_mis = 0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      r_fv  = $urandom_range(0, 9) < 6;
      r_pc  = 32'h4000 + ($urandom_range(0, 511) << 2);
      r_pt  = $urandom_range(0, 1) == 1;
      r_ptg = $urandom_range(0, 1) ? 32'h1000 : 32'h2000;
      r_rv  = $urandom_range(0, 9) < 6;
      r_rj  = $urandom_range(0, 4) == 0;
      r_rb  = $urandom_range(0, 1) == 1;
      r_rt  = (mq.size() > 0 && $urandom_range(0, 1)) ? mq[0].pred_target : 32'h1000 * $urandom_range(1, 3);
      drive(r_fv, r_pc, r_pt, r_ptg, r_rv, r_rj, r_rb, r_rt);
      m_fr = fl_left == 0 && mq.size() < DEPTH;
      m_rr = fl_left == 0 && mq.size() > 0;
      #1;
      chk("rnd fetch_ready", {31'b0, bus.fetch_ready}, {31'b0, m_fr});
      chk("rnd res_ready", {31'b0, bus.res_ready}, {31'b0, m_rr});
      pop = r_rv && m_rr;
      push = r_fv && m_fr;
      mis = 0;
      e_uv = pop;
      e_rv = 0;
      if (fl_left > 0) fl_left--;
      if (pop) begin
        h = mq.pop_front();
        act = r_rb | r_rj;
        e_idx = h.pc[IDX_W-1:0];
        e_ut = act;
        e_uj = r_rj;
        mis = (act != h.pred_taken) || (act && h.pred_target != r_rt);
        if (m_br != 32'hFFFF_FFFF) m_br++;
        if (mis) begin
          e_rv = 1;
          e_rpc = act ? r_rt : h.pc + 32'd4;
          mq.delete();
          fl_left = FC;
          if (m_mis != 32'hFFFF_FFFF) m_mis++;
        end
      end
      if (push && !mis) mq.push_back('{r_pc, r_pt, r_ptg});
      @(posedge clk);
      #1;
      chk("rnd upd_valid", {31'b0, bus.upd_valid}, {31'b0, e_uv});
      chk("rnd redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, e_rv});
      chk("rnd flush", {31'b0, bus.flush}, {31'b0, fl_left > 0});
      chk("rnd stat_branches", bus.stat_branches, m_br);
      chk("rnd stat_mispredicts", bus.stat_mispredicts, m_mis);
      if (e_uv) begin
        chk("rnd upd_index", {22'b0, bus.upd_index}, {22'b0, e_idx});
        chk("rnd upd_taken", {31'b0, bus.upd_taken}, {31'b0, e_ut});
        chk("rnd upd_jump", {31'b0, bus.upd_jump}, {31'b0, e_uj});
      end
      if (e_rv) chk("rnd redirect_pc", bus.redirect_pc, e_rpc);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
